// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// abs_w works on a 64-bit container, so operand widths up to 64 bits are supported.
package seq_div_pkg;

  localparam int STATE_W = 3;
  localparam int ABS_W   = 64;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  // Conditional two's-complement negate; callers truncate the result back to their width.
  function automatic logic [ABS_W-1:0] abs_w(input logic [ABS_W-1:0] x, input logic neg);
    logic [ABS_W-1:0] r;
    if (neg) begin
      r = ~x + ABS_W'(1'b1);
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  assign shifted_s = {rem, quo_msb};
  // The extra top bit of the subtraction acts as the borrow flag.
  assign diff_s    = shifted_s - {1'b0, dvs};
  assign q_bit     = ~diff_s[WIDTH];
  assign rem_next  = q_bit ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];

endmodule

// File: rtl/seq_div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: valid/ready in, WIDTH restoring steps, valid/ready out.
// Signed results truncate toward zero; divide-by-zero yields all-ones quotient and the raw dividend.
module seq_div_ctrl
  import seq_div_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           state_r;
  state_e           state_n;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] abs_dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic [CNT_W-1:0] cnt_r;
  logic             signed_r;
  logic             neg_q_r;
  logic             neg_rem_r;
  logic             zero_r;
  logic             div_by_zero_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic             accept_s;
  logic             last_iter_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] abs_dvd_s;
  logic [WIDTH-1:0] abs_dvs_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] fix_q_s;
  logic [WIDTH-1:0] fix_r_s;

  assign accept_s    = in_valid & in_ready_r;
  assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));
  assign dvd_neg_s   = signed_r & dividend_r[WIDTH-1];
  assign dvs_neg_s   = signed_r & divisor_r[WIDTH-1];
  // Most-negative operand negates to itself, which read as unsigned is the correct magnitude.
  assign abs_dvd_s   = WIDTH'(abs_w(ABS_W'(dividend_r), dvd_neg_s));
  assign abs_dvs_s   = WIDTH'(abs_w(ABS_W'(divisor_r), dvs_neg_s));
  assign fix_q_s     = zero_r ? {WIDTH{1'b1}} : WIDTH'(abs_w(ABS_W'(quo_r), neg_q_r));
  assign fix_r_s     = zero_r ? dividend_r : WIDTH'(abs_w(ABS_W'(rem_r), neg_rem_r));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo_msb  (quo_r[WIDTH-1]),
    .dvs      (abs_dvs_r),
    .rem_next (rem_next_s),
    .q_bit    (q_bit_s)
  );

  // Next-state decode for the division sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = PREP;
        end else begin
          state_n = IDLE;
        end
      end
      PREP: begin
        // Zero divisor still passes through FIX so every result is formatted in one place.
        if (divisor_r == {WIDTH{1'b0}}) begin
          state_n = FIX;
        end else begin
          state_n = CALC;
        end
      end
      CALC: begin
        if (last_iter_s) begin
          state_n = FIX;
        end else begin
          state_n = CALC;
        end
      end
      FIX:  state_n = DONE;
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_r    <= {WIDTH{1'b0}};
      divisor_r     <= {WIDTH{1'b0}};
      signed_r      <= 1'b0;
      abs_dvs_r     <= {WIDTH{1'b0}};
      rem_r         <= {WIDTH{1'b0}};
      quo_r         <= {WIDTH{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      neg_q_r       <= 1'b0;
      neg_rem_r     <= 1'b0;
      zero_r        <= 1'b0;
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dividend_r    <= dividend;
            divisor_r     <= divisor;
            signed_r      <= is_signed;
            div_by_zero_r <= 1'b0;
          end
        end
        PREP: begin
          abs_dvs_r <= abs_dvs_s;
          quo_r     <= abs_dvd_s;
          rem_r     <= {WIDTH{1'b0}};
          cnt_r     <= {CNT_W{1'b0}};
          neg_q_r   <= dvd_neg_s ^ dvs_neg_s;
          neg_rem_r <= dvd_neg_s;
          zero_r    <= (divisor_r == {WIDTH{1'b0}});
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[WIDTH-2:0], q_bit_s};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        FIX: begin
          quotient_r    <= fix_q_s;
          remainder_r   <= fix_r_s;
          div_by_zero_r <= zero_r;
        end
        DONE: begin
          quotient_r <= quotient_r;
        end
        default: begin
          quotient_r <= quotient_r;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Directed self-checking bench for seq_div_ctrl (WIDTH=8): sign matrix, divide-by-zero, boundaries,
// backpressure and reset during iteration.
module tb_seq_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       is_signed;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_div_ctrl #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one operand pair for exactly one accepting edge,
  // then scrambles the operand inputs so late changes would show up in the result.
  task automatic do_accept(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    dividend  = 8'h5A;
    divisor   = 8'h00;
    is_signed = ~s;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic chk_result(input string tag, input logic [7:0] eq, input logic [7:0] er, input logic ez);
    chk({tag, "_quotient"},  {24'd0, quotient},    {24'd0, eq});
    chk({tag, "_remainder"}, {24'd0, remainder},   {24'd0, er});
    chk({tag, "_dbz"},       {31'd0, div_by_zero}, {31'd0, ez});
    chk({tag, "_busy"},      {31'd0, in_ready},    32'd0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, in_ready},  32'd1);
  endtask

  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [7:0] eq, input logic [7:0] er, input logic ez, input int lat);
    do_accept(tag, a, b, s);
    wait_valid(tag, lat);
    chk_result(tag, eq, er, ez);
    consume(tag);
  endtask

  initial begin
    int spurious;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 8'h00;
    divisor   = 8'h00;
    is_signed = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_quotient",  {24'd0, quotient},    32'd0);
    chk("rst_remainder", {24'd0, remainder},   32'd0);
    chk("rst_dbz",       {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Unsigned and signed sign matrix (|10| / |4| = 2 r 2).
    run_div("u_10_4",   8'd10, 8'd4,  1'b0, 8'd2,  8'd2,  1'b0, 10);
    run_div("s_m10_4",  8'hF6, 8'h04, 1'b1, 8'hFE, 8'hFE, 1'b0, 10);
    run_div("s_10_m4",  8'h0A, 8'hFC, 1'b1, 8'hFE, 8'h02, 1'b0, 10);
    run_div("s_m10_m4", 8'hF6, 8'hFC, 1'b1, 8'h02, 8'hFE, 1'b0, 10);
    run_div("s_10_4",   8'h0A, 8'h04, 1'b1, 8'h02, 8'h02, 1'b0, 10);

    // Divide by zero, then a normal division clears the flag.
    run_div("u_37_0",   8'd37, 8'd0,  1'b0, 8'hFF, 8'd37, 1'b1, 2);
    run_div("u_9_3",    8'd9,  8'd3,  1'b0, 8'd3,  8'd0,  1'b0, 10);
    run_div("s_m10_0",  8'hF6, 8'h00, 1'b1, 8'hFF, 8'hF6, 1'b1, 2);

    // Boundaries: signed overflow, full-scale unsigned, divisor larger than dividend.
    run_div("s_m128_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 10);
    run_div("u_255_1",   8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 10);
    run_div("u_3_200",   8'd3,  8'd200, 1'b0, 8'd0, 8'd3,  1'b0, 10);

    // Backpressure: result held for 5 cycles, a stray in_valid pulse must be ignored.
    do_accept("bp", 8'd100, 8'd7, 1'b0);
    wait_valid("bp", 10);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        dividend = 8'h11;
        divisor  = 8'h01;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk("bp_hold_q",     {24'd0, quotient},  32'h0E);
      chk("bp_hold_r",     {24'd0, remainder}, 32'h02);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_busy",  {31'd0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    consume("bp");
    tick();
    tick();
    chk("bp_no_second", {31'd0, out_valid}, 32'd0);
    chk("bp_idle",      {31'd0, in_ready},  32'd1);

    // Reset during the 4th CALC iteration of 100/7.
    do_accept("rst_mid", 8'd100, 8'd7, 1'b0);
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready",  {31'd0, in_ready},    32'd1);
    chk("rst_mid_out_valid", {31'd0, out_valid},   32'd0);
    chk("rst_mid_quotient",  {24'd0, quotient},    32'd0);
    chk("rst_mid_remainder", {24'd0, remainder},   32'd0);
    chk("rst_mid_dbz",       {31'd0, div_by_zero}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        spurious++;
      end else begin
        spurious = spurious;
      end
    end
    chk("rst_mid_no_valid", 32'(spurious), 32'd0);
    chk("rst_mid_ready",    {31'd0, in_ready}, 32'd1);
    run_div("u_100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
